n64_response_receiver: RTL and testbench

Console-side receiver for the N64 joybus reply. After the request transmitter finishes a 0x01 (controller state) or 0x00 (identity) command, this block samples the open-drain data line, decodes the controller's pulse-width-coded bits and captures a 32-bit state word or 24-bit identity word. It presents the word with a one-cycle valid strobe, or signals an error on timeout or malformed pulses. Line tristating and drive are handled outside this block; it only observes the pin.

---
 rtl/n64_response_receiver.sv | 151 +++++++++++++++
 tb/tb_n64_response_receiver.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_response_receiver.sv
`timescale 1ns/1ps
// N64 joybus reply receiver: samples the open-drain data pin, decodes
// pulse-width-coded bits and presents a 32-bit state or 24-bit identity word.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for arm; pin edges ignored
// S_WAIT_START | armed, waiting for the first falling edge (no-response timeout)
// S_LOW      | inside a bit's low phase; low width decides the bit value
// S_HIGH     | inside a bit's high phase; next fall starts a bit or the stop
// S_STOP     | stop pulse low phase; rise completes the frame
module n64_response_receiver #(
   parameter int CYC_US       = 50,
   parameter int START_TO_US  = 100,
   parameter int MAX_PHASE_US = 5
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        n64d,
   input  logic        arm,
   input  logic        request_type,
   output logic [31:0] data,
   output logic        valid,
   output logic        error,
   output logic        busy
);

   localparam logic [15:0] START_LIM = 16'(START_TO_US * CYC_US - 1);
   localparam logic [15:0] PHASE_LIM = 16'(MAX_PHASE_US * CYC_US - 1);
   localparam logic [15:0] BIT_THR   = 16'(2 * CYC_US);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_LOW,
      S_HIGH,
      S_STOP
   } state_t;

   state_t      state;
   logic [1:0]  sync_q;
   logic        hist_q;
   logic        cur;
   logic        fall;
   logic        rise;
   logic [15:0] timer;
   logic [31:0] shift_q;
   logic [5:0]  bit_cnt;
   logic [5:0]  nbits;

   // Synchronizer and history idle high so reset never fakes an edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q <= 2'b11;
         hist_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], n64d};
         hist_q <= sync_q[1];
      end
   end

   assign cur  = sync_q[1];
   assign fall = hist_q & ~cur;
   assign rise = ~hist_q & cur;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= S_IDLE;
         timer   <= '0;
         shift_q <= '0;
         bit_cnt <= '0;
         nbits   <= 6'd32;
         data    <= '0;
         valid   <= 1'b0;
         error   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         valid <= 1'b0;
         error <= 1'b0;
         if (fall || rise) begin
            timer <= '0;
         end else begin
            timer <= timer + 16'd1;
         end

         case (state)
            S_IDLE: begin
               if (arm) begin
                  shift_q <= '0;
                  bit_cnt <= '0;
                  nbits   <= request_type ? 6'd32 : 6'd24;
                  busy    <= 1'b1;
                  timer   <= '0;
                  state   <= S_WAIT_START;
               end
            end
            S_WAIT_START: begin
               if (fall) begin
                  state <= S_LOW;
               end else if (timer == START_LIM) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  timer <= '0;
                  state <= S_IDLE;
               end
            end
            S_LOW: begin
               if (rise) begin
                  shift_q <= {shift_q[30:0], (timer < BIT_THR)};
                  bit_cnt <= bit_cnt + 6'd1;
                  state   <= S_HIGH;
               end else if (timer == PHASE_LIM) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  timer <= '0;
                  state <= S_IDLE;
               end
            end
            S_HIGH: begin
               if (fall) begin
                  state <= (bit_cnt < nbits) ? S_LOW : S_STOP;
               end else if (timer == PHASE_LIM) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  timer <= '0;
                  state <= S_IDLE;
               end
            end
            S_STOP: begin
               if (rise) begin
                  data  <= shift_q;
                  valid <= 1'b1;
                  busy  <= 1'b0;
                  timer <= '0;
                  state <= S_IDLE;
               end else if (timer == PHASE_LIM) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  timer <= '0;
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_n64_response_receiver.sv
`timescale 1ns/1ps
// Bench for n64_response_receiver: directed joybus replies against an
// event-level reply model, compared every cycle, plus literal frame results.
module tb_n64_response_receiver;

   localparam int CYC       = 50;
   localparam int START_LIM = 100 * CYC;   // cycles allowed before first fall
   localparam int PHASE_LIM = 5 * CYC;     // cycles allowed per low/high phase
   localparam int BIT_LIM   = 2 * CYC;     // measured low below this decodes 1

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        n64d = 1'b1;
   logic        arm = 1'b0;
   logic        request_type = 1'b0;
   logic [31:0] data;
   logic        valid;
   logic        error;
   logic        busy;

   n64_response_receiver dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .n64d         (n64d),
      .arm          (arm),
      .request_type (request_type),
      .data         (data),
      .valid        (valid),
      .error        (error),
      .busy         (busy)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc++;

   int checks = 0;
   int failures = 0;
   int fail_prints = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         if (fail_prints < 40) begin
            $display("FAIL %s: got %h required %h at cycle %0d", name, act, req, cyc);
            fail_prints++;
         end
      end
   endtask

   // Model: expected outcome of the current frame.
   bit          m_active = 1'b0;
   int          m_a = 0;
   int          m_end = 0;
   int          m_kind = 0;          // 0 none, 1 valid, 2 error
   logic [31:0] m_new = '0;
   logic [31:0] m_data = '0;

   int ph[$];   // phase durations: initial high, then alternating low/high, last is stop low
   int tt[$];   // edge index at which each pin transition is first sampled

   task automatic model_clear();
      m_active = 1'b0;
      m_kind   = 0;
      m_end    = 0;
      m_new    = '0;
      m_data   = '0;
   endtask

   // Each pin transition sampled at edge t is seen by the decoder at edge t+2;
   // a phase's measured width is the gap between detections minus one.
   task automatic model_frame(input int a, input bit rt);
      int last, lim, st, nb, bits, d;
      logic [31:0] w;
      bit done;
      if (m_kind == 1) m_data = m_new;
      nb = rt ? 32 : 24;
      last = a; lim = START_LIM; st = 0; bits = 0; w = '0; done = 1'b0;
      m_kind = 2; m_end = 0;
      foreach (tt[i]) begin
         if (!done) begin
            d = tt[i] + 2;
            if (d - last > lim) begin
               m_kind = 2; m_end = last + lim; done = 1'b1;
            end else begin
               case (st)
                  0: begin st = 1; lim = PHASE_LIM; end
                  1: begin
                     w = (w << 1) | 32'(((d - last - 1) < BIT_LIM) ? 1 : 0);
                     bits++;
                     st = 2;
                  end
                  2: st = (bits < nb) ? 1 : 3;
                  default: begin m_kind = 1; m_end = d; m_new = w; done = 1'b1; end
               endcase
               last = d;
            end
         end
      end
      if (!done) begin
         m_kind = 2; m_end = last + lim;
      end
      m_a = a;
      m_active = 1'b1;
   endtask

   int n_valid = 0;
   int n_error = 0;
   int last_v = 0;
   int last_e = 0;
   int last_a = 0;

   always @(posedge sys_clk) begin
      logic exp_v, exp_e, exp_b;
      logic [31:0] exp_d;
      #1;
      exp_v = m_active && m_kind == 1 && cyc == m_end;
      exp_e = m_active && m_kind == 2 && cyc == m_end;
      exp_b = m_active && cyc >= m_a && cyc < m_end;
      exp_d = (m_active && m_kind == 1 && cyc >= m_end) ? m_new : m_data;
      check("ctrl{valid,error,busy}", {29'b0, valid, error, busy}, {29'b0, exp_v, exp_e, exp_b});
      check("data", data, exp_d);
      if (valid === 1'b1) begin n_valid++; last_v = cyc; end
      if (error === 1'b1) begin n_error++; last_e = cyc; end
   end

   task automatic build(input logic [31:0] w, input int n, input int h0);
      ph.delete();
      ph.push_back(h0);
      for (int i = n - 1; i >= 0; i--) begin
         ph.push_back(w[i] ? CYC : 3 * CYC);
         ph.push_back(w[i] ? 3 * CYC : CYC);
      end
      ph.push_back(2 * CYC);
   endtask

   task automatic run_frame(input bit rt, input int arm2_rel, input int abort_rel);
      int a, k, t, arm2_t, abort_t;
      bit aborted;
      @(negedge sys_clk);
      arm = 1'b1;
      request_type = rt;
      a = cyc + 1;
      tt.delete();
      t = a;
      foreach (ph[i]) begin t += ph[i]; tt.push_back(t); end
      model_frame(a, rt);
      last_a = a;
      arm2_t  = (arm2_rel != 0) ? a + arm2_rel : -1;
      abort_t = (abort_rel != 0) ? a + abort_rel : -1;
      @(negedge sys_clk);
      arm = 1'b0;
      request_type = ~rt;
      k = 0;
      aborted = 1'b0;
      while (k < tt.size() && !aborted) begin
         arm = (cyc + 1 == arm2_t);
         if (cyc + 1 == abort_t) begin
            sys_rst_n = 1'b0;
            n64d = 1'b1;
            model_clear();
            aborted = 1'b1;
         end else if (cyc + 1 == tt[k]) begin
            n64d = (k % 2 == 1);
            k++;
         end
         @(negedge sys_clk);
      end
      arm = 1'b0;
      if (aborted) begin
         repeat (4) begin
            check("reset_data", data, 32'h0);
            check("reset_flags", {29'b0, valid, error, busy}, 32'h0);
            @(negedge sys_clk);
         end
         sys_rst_n = 1'b1;
      end
      while (cyc < m_end + 10) @(negedge sys_clk);
      repeat (20) @(negedge sys_clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion at cycle %0d", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v0, e0;
      repeat (5) @(negedge sys_clk);
      check("reset_data0", data, 32'h0);
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);

      // Nominal state reply.
      v0 = n_valid; e0 = n_error;
      build(32'h8000_1234, 32, 40);
      run_frame(1'b1, 0, 0);
      check("state_model", m_new, 32'h8000_1234);
      check("state_data", data, 32'h8000_1234);
      check("state_valid_count", 32'(n_valid - v0), 32'd1);
      check("state_error_count", 32'(n_error - e0), 32'd0);
      check("valid_latency", 32'(last_v - tt[tt.size() - 1]), 32'd2);

      // Identity reply with a stray arm (request_type=1) mid-frame.
      v0 = n_valid; e0 = n_error;
      build(32'h0005_0002, 24, 40);
      run_frame(1'b0, 3000, 0);
      check("ident_data", data, 32'h0005_0002);
      check("ident_valid_count", 32'(n_valid - v0), 32'd1);
      check("ident_error_count", 32'(n_error - e0), 32'd0);

      // No response at all.
      e0 = n_error;
      ph.delete();
      run_frame(1'b1, 0, 0);
      check("noresp_error_count", 32'(n_error - e0), 32'd1);
      check("noresp_latency", 32'(last_e - last_a), 32'd5000);
      check("noresp_data", data, 32'h0005_0002);

      // Line held low 300 cycles after five bits.
      v0 = n_valid; e0 = n_error;
      build(32'h0000_0016, 5, 40);
      ph[ph.size() - 1] = 300;
      run_frame(1'b1, 0, 0);
      check("stuck_error_count", 32'(n_error - e0), 32'd1);
      check("stuck_valid_count", 32'(n_valid - v0), 32'd0);
      check("stuck_latency", 32'(last_e - tt[10]), 32'd252);

      // Decision boundary: pin lows of 100 and 101 cycles measure 99 and 100.
      build(32'h0, 32, 40);
      ph[1] = 100;
      ph[3] = 101;
      run_frame(1'b1, 0, 0);
      check("boundary_model", m_new, 32'h8000_0000);
      check("boundary_data", data, 32'h8000_0000);

      // Reset mid-frame, then a fresh all-ones reply.
      v0 = n_valid; e0 = n_error;
      build(32'h1234_5678, 32, 40);
      run_frame(1'b1, 0, 2000);
      check("abort_valid_count", 32'(n_valid - v0), 32'd0);
      check("abort_error_count", 32'(n_error - e0), 32'd0);
      check("abort_data", data, 32'h0);
      build(32'hFFFF_FFFF, 32, 40);
      run_frame(1'b1, 0, 0);
      check("ones_data", data, 32'hFFFF_FFFF);
      check("ones_valid_count", 32'(n_valid - v0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
